// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the neurocrypt round timer: state encoding and default width.
package countdown_timer_pkg;

   localparam int unsigned NC_CNT_W = 5;

   typedef enum logic [1:0] {
      CT_IDLE = 2'd0,
      CT_RUN  = 2'd1,
      CT_HOLD = 2'd2
   } ct_state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause handshake and a one-cycle tc pulse on expiry.
// One-shot or periodic operation selected by AUTO_RELOAD.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned WIDTH       = NC_CNT_W,
   parameter int unsigned AUTO_RELOAD = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy
);

   ct_state_e        state, state_n;
   logic [WIDTH-1:0] count_n;
   logic [WIDTH-1:0] reload_reg, reload_n;
   logic             tc_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= CT_IDLE;
         count      <= '0;
         reload_reg <= '0;
         tc         <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         reload_reg <= reload_n;
         tc         <= tc_n;
      end
   end

   always_comb begin
      state_n  = state;
      count_n  = count;
      reload_n = reload_reg;
      tc_n     = 1'b0;
      if (load) begin
         count_n  = load_val;
         reload_n = load_val;
         state_n  = CT_IDLE;
      end else begin
         unique case (state)
            CT_IDLE: begin
               if (start) begin
                  if (count != '0) state_n = CT_RUN;
                  else             tc_n    = 1'b1;
               end
            end
            CT_RUN: begin
               if (pause) begin
                  state_n = CT_HOLD;
               end else if (count == '0) begin
                  // Only periodic mode sits in RUN at zero: reload instead of decrementing.
                  count_n = reload_reg;
                  tc_n    = (reload_reg == '0);
                  if (AUTO_RELOAD == 0) state_n = CT_IDLE;
               end else begin
                  count_n = count - WIDTH'(1);
                  if (count == WIDTH'(1)) begin
                     tc_n = 1'b1;
                     if (AUTO_RELOAD == 0) state_n = CT_IDLE;
                  end
               end
            end
            CT_HOLD: begin
               if (!pause) state_n = CT_RUN;
            end
            default: state_n = CT_IDLE;
         endcase
      end
   end

   assign busy = (state != CT_IDLE);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: one-shot and periodic instances share stimulus.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load = 1'b0;
   logic [4:0] load_val = '0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [4:0] count0, count1;
   logic       tc0, tc1, busy0, busy1;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   typedef struct {
      string      tag;
      int         sel;
      logic [4:0] c;
      logic       t;
      logic       b;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   countdown_timer #(.WIDTH(5), .AUTO_RELOAD(0)) dut0 (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .count(count0), .tc(tc0), .busy(busy0)
   );

   countdown_timer #(.WIDTH(5), .AUTO_RELOAD(1)) dut1 (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .count(count1), .tc(tc1), .busy(busy1)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_dut(input string tag, input int sel,
                            input logic [4:0] c, input logic t, input logic b);
      if (sel == 0) begin
         check({tag, ".count"}, int'(count0), int'(c));
         check({tag, ".tc"},    int'(tc0),    int'(t));
         check({tag, ".busy"},  int'(busy0),  int'(b));
      end else begin
         check({tag, ".count"}, int'(count1), int'(c));
         check({tag, ".tc"},    int'(tc1),    int'(t));
         check({tag, ".busy"},  int'(busy1),  int'(b));
      end
   endtask

   // Drive one cycle of stimulus, queue its expected result, compare after the edge.
   task automatic cyc(input string tag, input int sel,
                      input logic l, input logic [4:0] lv, input logic s, input logic p,
                      input logic [4:0] ec, input logic et, input logic eb);
      exp_t e;
      exp_t g;
      @(negedge clk);
      load = l; load_val = lv; start = s; pause = p;
      e.tag = tag; e.sel = sel; e.c = ec; e.t = et; e.b = eb;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      check_dut(g.tag, g.sel, g.c, g.t, g.b);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      #1;
      check_dut("rst0", 0, 5'd0, 1'b0, 1'b0);
      check_dut("rst1", 1, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // one-shot N=5
      cyc("t2.load", 0, 1, 5'd5, 0, 0, 5'd5, 0, 0);
      cyc("t2.start", 0, 0, 5'd0, 1, 0, 5'd5, 0, 1);
      cyc("t2.c4", 0, 0, 5'd0, 0, 0, 5'd4, 0, 1);
      cyc("t2.c3", 0, 0, 5'd0, 0, 0, 5'd3, 0, 1);
      cyc("t2.c2", 0, 0, 5'd0, 0, 0, 5'd2, 0, 1);
      cyc("t2.c1", 0, 0, 5'd0, 0, 0, 5'd1, 0, 1);
      cyc("t2.c0", 0, 0, 5'd0, 0, 0, 5'd0, 1, 0);
      cyc("t2.idle", 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);

      // pause: three pause edges, then resume edge without decrement
      cyc("t3.load", 0, 1, 5'd4, 0, 0, 5'd4, 0, 0);
      cyc("t3.start", 0, 0, 5'd0, 1, 0, 5'd4, 0, 1);
      cyc("t3.c3", 0, 0, 5'd0, 0, 0, 5'd3, 0, 1);
      cyc("t3.c2", 0, 0, 5'd0, 0, 0, 5'd2, 0, 1);
      cyc("t3.hold1", 0, 0, 5'd0, 0, 1, 5'd2, 0, 1);
      cyc("t3.hold2", 0, 0, 5'd0, 0, 1, 5'd2, 0, 1);
      cyc("t3.hold3", 0, 0, 5'd0, 1, 1, 5'd2, 0, 1);
      cyc("t3.resume", 0, 0, 5'd0, 0, 0, 5'd2, 0, 1);
      cyc("t3.c1", 0, 0, 5'd0, 0, 0, 5'd1, 0, 1);
      cyc("t3.c0", 0, 0, 5'd0, 0, 0, 5'd0, 1, 0);

      // periodic N=3 on the auto-reload instance
      cyc("t4.load", 1, 1, 5'd3, 0, 0, 5'd3, 0, 0);
      cyc("t4.start", 1, 0, 5'd0, 1, 0, 5'd3, 0, 1);
      for (int r = 0; r < 2; r++) begin
         cyc("t4.c2", 1, 0, 5'd0, 0, 0, 5'd2, 0, 1);
         cyc("t4.c1", 1, 0, 5'd0, 0, 0, 5'd1, 0, 1);
         cyc("t4.c0", 1, 0, 5'd0, 0, 0, 5'd0, 1, 1);
         cyc("t4.reload", 1, 0, 5'd0, 0, 0, 5'd3, 0, 1);
      end
      cyc("t4.stop", 1, 1, 5'd0, 0, 0, 5'd0, 0, 0);

      // load aborts a running round; load beats start
      cyc("t5.load", 0, 1, 5'd5, 0, 0, 5'd5, 0, 0);
      cyc("t5.start", 0, 0, 5'd0, 1, 0, 5'd5, 0, 1);
      cyc("t5.c4", 0, 0, 5'd0, 0, 0, 5'd4, 0, 1);
      cyc("t5.c3", 0, 0, 5'd0, 0, 0, 5'd3, 0, 1);
      cyc("t5.c2", 0, 0, 5'd0, 0, 0, 5'd2, 0, 1);
      cyc("t5.abort", 0, 1, 5'd9, 0, 0, 5'd9, 0, 0);
      cyc("t5.idle", 0, 0, 5'd0, 0, 0, 5'd9, 0, 0);
      cyc("t5.ldstart", 0, 1, 5'd6, 1, 0, 5'd6, 0, 0);
      cyc("t5.idle2", 0, 0, 5'd0, 0, 0, 5'd6, 0, 0);

      // start at zero gives a lone tc; start while running is ignored
      cyc("t6.load0", 0, 1, 5'd0, 0, 0, 5'd0, 0, 0);
      cyc("t6.start0", 0, 0, 5'd0, 1, 0, 5'd0, 1, 0);
      cyc("t6.after0", 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
      cyc("t6.load3", 0, 1, 5'd3, 0, 0, 5'd3, 0, 0);
      cyc("t6.start", 0, 0, 5'd0, 1, 0, 5'd3, 0, 1);
      cyc("t6.st2", 0, 0, 5'd0, 1, 0, 5'd2, 0, 1);
      cyc("t6.st1", 0, 0, 5'd0, 1, 0, 5'd1, 0, 1);
      cyc("t6.st0", 0, 0, 5'd0, 0, 0, 5'd0, 1, 0);
      cyc("t6.gap", 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);

      // asynchronous reset mid-round at count=7
      cyc("t1.load", 0, 1, 5'd8, 0, 0, 5'd8, 0, 0);
      cyc("t1.start", 0, 0, 5'd0, 1, 0, 5'd8, 0, 1);
      cyc("t1.c7", 0, 0, 5'd0, 0, 0, 5'd7, 0, 1);
      #2;
      rst = 1'b0;
      #1;
      check_dut("t1.async0", 0, 5'd0, 1'b0, 1'b0);
      check_dut("t1.async1", 1, 5'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_dut("t1.held", 0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      cyc("t1.post", 0, 0, 5'd0, 1, 0, 5'd0, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
